// File: rtl/field_serializer_if.sv
// Handshake bundle for field_serializer: parallel decoded-field lanes in,
// one serialized field (valid/ready) out.
interface field_serializer_if #(
    parameter int num_decoders     = 4,
    parameter int beat_width       = 64,
    parameter int max_message_size = 10,
    parameter int messageID_size   = 21
);
    localparam int IDX_W   = $clog2(max_message_size);
    localparam int FIELD_W = 2 + messageID_size + IDX_W + beat_width;

    logic [FIELD_W-1:0]        in_fields [0:num_decoders-1];
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [messageID_size-1:0] out_msg_id;
    logic [IDX_W-1:0]          out_idx;
    logic [beat_width-1:0]     out_data;
    logic                      out_last;

    modport master (
        output in_fields, out_ready,
        input  in_ready, out_valid, out_msg_id, out_idx, out_data, out_last
    );

    modport slave (
        input  in_fields, out_ready,
        output in_ready, out_valid, out_msg_id, out_idx, out_data, out_last
    );
endinterface

// File: rtl/field_serializer.sv
// Compacts up to num_decoders valid field lanes per cycle into a circular buffer
// and serializes them one per handshake, checking message index sequencing on pop.
module field_serializer #(
    parameter int num_decoders     = 4,
    parameter int beat_width       = 64,
    parameter int max_message_size = 10,
    parameter int messageID_size   = 21
) (
    input  logic        clk,
    input  logic        rstn,
    field_serializer_if.slave bus,
    output logic        seq_err,
    output logic [31:0] fields_out_cnt,
    output logic [15:0] msgs_out_cnt
);
    localparam int IDX_W   = $clog2(max_message_size);
    localparam int FIELD_W = 2 + messageID_size + IDX_W + beat_width;
    localparam int ENTRY_W = FIELD_W - 1;  // stored entry drops the valid bit
    localparam int DEPTH   = 2 * num_decoders;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CNT_W-1:0]          count, count_next, push_cnt;
    logic [PTR_W-1:0]          slot [num_decoders];
    logic [IDX_W-1:0]          exp_idx;
    logic [messageID_size-1:0] cur_id;
    logic                      pop, seq_bad;

    logic [ENTRY_W-1:0]        head;
    logic [messageID_size-1:0] head_msg_id;
    logic [IDX_W-1:0]          head_idx;
    logic                      head_last;

    assign head        = mem[rd_ptr];
    assign head_last   = head[ENTRY_W-1];
    assign head_msg_id = head[beat_width+IDX_W +: messageID_size];
    assign head_idx    = head[beat_width +: IDX_W];

    assign bus.in_ready   = (count <= CNT_W'(num_decoders));
    assign bus.out_valid  = (count != '0);
    assign bus.out_msg_id = head_msg_id;
    assign bus.out_idx    = head_idx;
    assign bus.out_data   = head[beat_width-1:0];
    assign bus.out_last   = head_last;

    assign pop         = bus.out_valid && bus.out_ready;
    assign rd_ptr_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    assign count_next  = count + push_cnt - CNT_W'(pop);

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        int pos;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pos      = int'(wr_ptr);
        push_cnt = '0;
        for (int lane = 0; lane < num_decoders; lane++) begin
            slot[lane] = pos[PTR_W-1:0];
            if (bus.in_ready && bus.in_fields[lane][FIELD_W-1]) begin
                push_cnt = push_cnt + CNT_W'(1);
                pos      = (pos == DEPTH - 1) ? 0 : pos + 1;
            end
        end
        wr_ptr_next = pos[PTR_W-1:0];
    end

    always_comb begin
        seq_bad = 1'b0;
        if (exp_idx == '0) begin
            seq_bad = (head_idx != '0);
        end else begin
            seq_bad = (head_msg_id != cur_id) || (head_idx != exp_idx);
        end
        if (int'(head_idx) >= max_message_size) begin
            seq_bad = 1'b1;
        end
    end

    // NOTE: storage carries no reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < num_decoders; lane++) begin
            if (bus.in_ready && bus.in_fields[lane][FIELD_W-1]) begin
                mem[slot[lane]] <= bus.in_fields[lane][ENTRY_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            exp_idx        <= '0;
            cur_id         <= '0;
            seq_err        <= 1'b0;
            fields_out_cnt <= '0;
            msgs_out_cnt   <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            count  <= count_next;
            if (pop) begin
                rd_ptr         <= rd_ptr_next;
                fields_out_cnt <= fields_out_cnt + 32'd1;
                if (head_last) begin
                    msgs_out_cnt <= msgs_out_cnt + 16'd1;
                end
                if (exp_idx == '0) begin
                    cur_id <= head_msg_id;
                end
                exp_idx <= head_last ? '0 : exp_idx + IDX_W'(1);
                if (seq_bad) begin
                    seq_err <= 1'b1;  // sticky until reset; data keeps flowing
                end
            end
        end
    end
endmodule
